// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, frame-size helpers and pixel types
package vga_pkg;
  localparam int H_ACTIVE_D = 800;
  localparam int H_FP_D     = 40;
  localparam int H_SYNC_D   = 128;
  localparam int H_BP_D     = 88;
  localparam int V_ACTIVE_D = 600;
  localparam int V_FP_D     = 1;
  localparam int V_SYNC_D   = 4;
  localparam int V_BP_D     = 23;
  localparam int RGB_W      = 3;
  typedef enum logic {MIX_OR = 1'b0, MIX_PRIO = 1'b1} mix_mode_e;
  function automatic int h_total(int a, int fp, int s, int bp);
    return a + fp + s + bp;
  endfunction
  function automatic int v_total(int a, int fp, int s, int bp);
    return a + fp + s + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with raw sync, active and frame-start
module vga_timing_gen import vga_pkg::*; #(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] c1,
  output logic [10:0] c2,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);
  localparam logic [10:0] H_END  = 11'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [10:0] V_END  = 11'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  logic [10:0] c1_q, c1_d, c2_q, c2_d;
  // column wraps at end of line; line advances only on that wrap
  always_comb begin
    c1_d = (c1_q == H_END) ? 11'd0 : c1_q + 11'd1;
    c2_d = (c1_q != H_END) ? c2_q : (c2_q == V_END) ? 11'd0 : c2_q + 11'd1;
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q <= '0;
      c2_q <= '0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end
  assign c1          = c1_q;
  assign c2          = c2_q;
  assign hsync       = (c1_q >= HS_BEG && c1_q < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (c2_q >= VS_BEG && c2_q < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign active      = (c1_q < HA) && (c2_q < VA);
  assign frame_start = (c1_q == '0) && (c2_q == '0);
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: VGA timing with per-frame shadowed multi-layer colour mixing
module vga_layer_mixer import vga_pkg::*; #(
  parameter int   H_ACTIVE   = H_ACTIVE_D,
  parameter int   H_FP       = H_FP_D,
  parameter int   H_SYNC     = H_SYNC_D,
  parameter int   H_BP       = H_BP_D,
  parameter int   V_ACTIVE   = V_ACTIVE_D,
  parameter int   V_FP       = V_FP_D,
  parameter int   V_SYNC     = V_SYNC_D,
  parameter int   V_BP       = V_BP_D,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   NUM_LAYERS = 4,
  parameter int   LAYER_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       cfg_layer_en,
  input  logic                        cfg_mode,
  output logic [10:0]                 c1,
  output logic [10:0]                 c2,
  output logic                        HSYNC_Sig,
  output logic                        VSYNC_Sig,
  output logic [4:0]                  Red_Sig,
  output logic [5:0]                  Green_Sig,
  output logic [4:0]                  Blue_Sig,
  output logic                        de,
  output logic                        frame_start
);
  localparam int D = LAYER_LAT + 1;
  typedef struct packed {logic fs; logic act; logic vs; logic hs;} ctl_t;
  localparam ctl_t CTL_IDLE = '{fs: 1'b0, act: 1'b0, vs: ~SYNC_POL, hs: ~SYNC_POL};
  logic hs_raw, vs_raw, act_raw, fs_raw;
  ctl_t pipe_q [D];
  ctl_t pipe_d [D];
  ctl_t ctl_o;
  logic [NUM_LAYERS-1:0] en_q, en_d;
  mix_mode_e mode_q, mode_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .c1(c1), .c2(c2),
    .hsync(hs_raw), .vsync(vs_raw), .active(act_raw), .frame_start(fs_raw)
  );
  // control delay line so sync/active/frame-start line up with the mixed pixel
  always_comb begin
    pipe_d[0] = '{fs: fs_raw, act: act_raw, vs: vs_raw, hs: hs_raw};
    for (int i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
  end
  // config is captured only on the first pixel of a frame
  always_comb begin
    en_d   = fs_raw ? cfg_layer_en : en_q;
    mode_d = fs_raw ? mix_mode_e'(cfg_mode) : mode_q;
  end
  // OR blend, or highest-index enabled non-transparent layer wins
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (en_q[i])
        rgb_d = (mode_q == MIX_PRIO) ? ((layer_rgb[RGB_W*i +: RGB_W] != '0) ? layer_rgb[RGB_W*i +: RGB_W] : rgb_d)
                                     : (rgb_d | layer_rgb[RGB_W*i +: RGB_W]);
  end
  // delay line, shadow config and mixed pixel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= CTL_IDLE;
      en_q   <= '0;
      mode_q <= MIX_OR;
      rgb_q  <= '0;
    end else begin
      for (int i = 0; i < D; i++) pipe_q[i] <= pipe_d[i];
      en_q   <= en_d;
      mode_q <= mode_d;
      rgb_q  <= rgb_d;
    end
  end
  assign ctl_o       = pipe_q[D-1];
  assign HSYNC_Sig   = ctl_o.hs;
  assign VSYNC_Sig   = ctl_o.vs;
  assign de          = ctl_o.act;
  assign frame_start = ctl_o.fs;
  assign Red_Sig     = {5{rgb_q[2] & ctl_o.act}};
  assign Green_Sig   = {6{rgb_q[1] & ctl_o.act}};
  assign Blue_Sig    = {5{rgb_q[0] & ctl_o.act}};
endmodule
